alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Upstream control stage of the 16-bit ALU. Accepts one instruction word per handshake and
//  decodes it. Emits register-file read addresses plus the ALU control strobes
//  (a_enable, addsub, xor_ctrl, mul_out_ctrl, acc_enable) over a fixed multi-cycle sequence.
//  Signals completion with a one-cycle done pulse.
// PARAMETERS
//  MUL_WAIT  2  extra EXEC cycles held before accumulator write on MUL (multiplier settle), 0..15
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst           in   1   synchronous, active-high reset
//  instr         in   16  [15:12] opcode, [11:8] src A reg, [7:4] src B reg, [3:0] unused
//  instr_valid   in   1   instr presented
//  instr_ready   out  1   high only in IDLE; transfer when instr_valid & instr_ready
//  rf_addr_a     out  4   reg-file read address for ALU operand a
//  rf_addr_b     out  4   reg-file read address for ALU operand b
//  a_enable      out  1   load ALU A register
//  addsub        out  1   1 = subtract (invert b, carry-in 1)
//  xor_ctrl      out  1   1 = XOR result onto accumulator input
//  mul_out_ctrl  out  1   1 = multiplier high half onto accumulator input
//  acc_enable    out  1   write accumulator pair (acc and mul_acc)
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse: instruction retired
//  err           out  1   one-cycle pulse coincident with done: illegal opcode
// BEHAVIOUR
//  Opcodes:
//   0 NOP, 1 ADD, 2 SUB, 3 XOR, 4 MUL, 5 LDA (load A only). 6..15 are illegal.
//  Reset:
//   state=IDLE, wait counter=0, latched instr=0.
//   All control outputs, done and err are 0; instr_ready=1; rf_addr_* = 0.
//  FSM: IDLE -> LOAD_A -> EXEC -> WRITE -> DONE -> IDLE. All outputs registered.
//   IDLE:
//    On handshake, latch instr.
//    NOP or illegal -> DONE directly; no enables asserted; err=1 in DONE if illegal.
//    Otherwise -> LOAD_A.
//   LOAD_A (1 cycle):
//    rf_addr_a/b driven from latched fields (held until IDLE) and a_enable=1.
//    LDA -> DONE. Otherwise -> EXEC.
//   EXEC:
//    Op controls driven: ADD 000, SUB 100, XOR 010, MUL 001 as {addsub,xor_ctrl,mul_out_ctrl}.
//    Non-MUL stays 1 cycle. MUL stays 1+MUL_WAIT cycles via a 4-bit down-counter
//    loaded with MUL_WAIT on entry; exit when counter==0.
//   WRITE (1 cycle):
//    Op controls held unchanged and acc_enable=1. -> DONE.
//   DONE (1 cycle):
//    done=1, all controls 0. -> IDLE, so instr_ready=1 on the following cycle.
//  Latency, handshake at cycle T:
//   ADD/SUB/XOR: a_enable T+1, acc_enable T+3, done T+4.
//   MUL: acc_enable T+3+MUL_WAIT, done T+4+MUL_WAIT.
//   LDA: done T+2. NOP/illegal: done T+1.
//  Invariants:
//   At most one of xor_ctrl/mul_out_ctrl high.
//   acc_enable never high with a_enable.
//   a_enable and acc_enable are each exactly one cycle per instruction.
//  Control stability: op controls stable for the whole EXEC+WRITE window; no glitch between them.
//  instr_valid while busy:
//   Ignored; instr_ready=0, instr not sampled.
//   Upstream must hold instr/instr_valid until accepted.
//  Reset mid-operation:
//   Next cycle is IDLE with all outputs at reset values.
//   No acc_enable is issued for the aborted instruction.
//  Back-to-back: with instr_valid held high, a new instruction is accepted the cycle after DONE.
// STRUCTURE
//  Shared package/include (alu_defs): opcode localparams (OP_NOP..OP_LDA), state encodings,
//   field bit positions.
//  One sub-module is natural: alu_op_decode (combinational, opcode -> {addsub,xor_ctrl,
//   mul_out_ctrl, is_mul, is_lda, illegal}).
//  FSM, wait counter and output registers live in this module.
// TESTING
//  1 rst held 3 cycles, release -> all strobes 0, instr_ready=1, busy=0.
//  2 ADD 0x1120 at T -> rf_addr_a=1, rf_addr_b=2; a_enable@T+1; acc_enable@T+3 with
//    addsub=0, xor_ctrl=0, mul_out_ctrl=0; done@T+4.
//  3 SUB, XOR, MUL with MUL_WAIT=2 -> correct control codes stable across EXEC+WRITE;
//    MUL acc_enable@T+5, done@T+6.
//  4 Instr 0x9000 (illegal) -> done and err @T+1, no a_enable/acc_enable; NOP 0x0000 ->
//    done@T+1, err=0.
//  5 instr_valid held high with ADD,LDA,XOR queued -> accepts each only when instr_ready=1;
//    no accept while busy; LDA done@T+2.
//  6 rst asserted in EXEC of MUL -> no acc_enable ever; next cycle IDLE; subsequent ADD
//    completes normally.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field positions,
// FSM state encoding and the decoded-opcode bundle.
package alu_sequencer_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic addsub;
    logic xor_ctrl;
    logic mul_out_ctrl;
    logic is_mul;
    logic is_lda;
    logic is_nop;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/alu_sequencer_op_decode.sv
// Opcode decoder: maps a 4-bit opcode to ALU control codes and sequencing flags.
// Latency: combinational. Backpressure: none, pure function of the opcode.
// Opcodes above LDA are flagged illegal with all controls low.
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP: dec.is_nop       = 1'b1;
      OP_ADD: ;
      OP_SUB: dec.addsub       = 1'b1;
      OP_XOR: dec.xor_ctrl     = 1'b1;
      OP_MUL: begin
        dec.mul_out_ctrl = 1'b1;
        dec.is_mul       = 1'b1;
      end
      OP_LDA: dec.is_lda       = 1'b1;
      default: dec.illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU control sequencer: decodes one instruction per handshake and steps IDLE/LOAD_A/EXEC/WRITE/DONE.
// Latency: done at T+4 (ALU ops), T+4+MUL_WAIT (MUL), T+2 (LDA), T+1 (NOP/illegal); outputs registered.
// Backpressure: instr_ready only in IDLE; instr_valid is ignored while busy.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  rf_addr_a,
  output logic [3:0]  rf_addr_b,
  output logic        a_enable,
  output logic        addsub,
  output logic        xor_ctrl,
  output logic        mul_out_ctrl,
  output logic        acc_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] MUL_WAIT_CNT = 4'(MUL_WAIT);

  state_t      state_q, state_d;
  logic [15:4] instr_q, instr_d;
  logic [3:0]  cnt_q, cnt_d;
  dec_t        dec;
  logic        accept;
  logic        in_op;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instr[3:0];

  // Decode the word that will be held next cycle, so IDLE sees the incoming opcode.
  assign accept  = (state_q == ST_IDLE) && instr_valid;
  assign instr_d = accept ? instr[15:4] : instr_q;

  alu_op_decode u_op_decode (
    .opcode (instr_d[OPC_HI:OPC_LO]),
    .dec    (dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (dec.is_nop || dec.illegal) ? ST_DONE : ST_LOAD_A;
      end
      ST_LOAD_A: begin
        if (dec.is_lda) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_EXEC;
          cnt_d   = dec.is_mul ? MUL_WAIT_CNT : 4'd0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) state_d = ST_WRITE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign in_op = (state_d == ST_EXEC) || (state_d == ST_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      cnt_q        <= '0;
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      rf_addr_a    <= '0;
      rf_addr_b    <= '0;
      a_enable     <= 1'b0;
      addsub       <= 1'b0;
      xor_ctrl     <= 1'b0;
      mul_out_ctrl <= 1'b0;
      acc_enable   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      instr_ready  <= (state_d == ST_IDLE);
      busy         <= (state_d != ST_IDLE);
      rf_addr_a    <= (state_d == ST_IDLE) ? 4'd0 : instr_d[RA_HI:RA_LO];
      rf_addr_b    <= (state_d == ST_IDLE) ? 4'd0 : instr_d[RB_HI:RB_LO];
      a_enable     <= (state_d == ST_LOAD_A);
      addsub       <= in_op && dec.addsub;
      xor_ctrl     <= in_op && dec.xor_ctrl;
      mul_out_ctrl <= in_op && dec.mul_out_ctrl;
      acc_enable   <= (state_d == ST_WRITE);
      done         <= (state_d == ST_DONE);
      err          <= (state_d == ST_DONE) && dec.illegal;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a per-instruction output schedule built from the latency table,
// compared every cycle, plus literal latency/control checks on directed instructions.
module tb_alu_sequencer;

  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, a_enable, addsub, xor_ctrl, mul_out_ctrl, acc_enable, busy, done, err;
  logic [3:0]  rf_addr_a, rf_addr_b;

  alu_sequencer #(.MUL_WAIT(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .rf_addr_a    (rf_addr_a),
    .rf_addr_b    (rf_addr_b),
    .a_enable     (a_enable),
    .addsub       (addsub),
    .xor_ctrl     (xor_ctrl),
    .mul_out_ctrl (mul_out_ctrl),
    .acc_enable   (acc_enable),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // ctl = {instr_ready, busy, a_enable, addsub, xor_ctrl, mul_out_ctrl, acc_enable, done, err}
  typedef struct packed {
    logic [8:0] ctl;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       chk_addr;
  } exp_t;

  exp_t sched[$];
  exp_t exp_v;
  bit   model_on = 0;
  int   total = 0, bad = 0;
  int   cyc = 0, hs_cyc = 0, hs_count = 0;
  int   a_lat = -1, acc_lat = -1, done_lat = -1, a_cnt = 0, acc_cnt = 0, acc_since_rst = 0;
  int   a_ra = 0, a_rb = 0, acc_ctl = 0, err_seen = 0;

  function automatic exp_t mk(logic [8:0] ctl, logic [3:0] ra, logic [3:0] rb, logic chk);
    exp_t e;
    e.ctl = ctl; e.ra = ra; e.rb = rb; e.chk_addr = chk;
    return e;
  endfunction

  // Cycle-by-cycle outputs following an accepted instruction, straight from the latency table.
  function automatic void build(logic [15:0] w);
    logic [3:0] opc, ra, rb;
    logic [2:0] code;
    opc = w[15:12]; ra = w[11:8]; rb = w[7:4];
    if (opc == 4'd0 || opc > 4'd5) begin
      sched.push_back(mk({2'b01, 6'b000000, opc > 4'd5}, '0, '0, 1'b0) | exp_t'({9'b000000010, 9'b0}));
    end else begin
      sched.push_back(mk(9'b011000000, ra, rb, 1'b1));
      if (opc == 4'd5) begin
        sched.push_back(mk(9'b010000010, ra, rb, 1'b1));
      end else begin
        case (opc)
          4'd1: code = 3'b000;
          4'd2: code = 3'b100;
          4'd3: code = 3'b010;
          default: code = 3'b001;
        endcase
        for (int n = 0; n <= ((opc == 4'd4) ? MW : 0); n++)
          sched.push_back(mk({3'b010, code, 3'b000}, ra, rb, 1'b1));
        sched.push_back(mk({3'b010, code, 3'b100}, ra, rb, 1'b1));
        sched.push_back(mk(9'b010000010, ra, rb, 1'b1));
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
      exp_v = mk(9'b100000000, '0, '0, 1'b1);
      model_on = 1;
    end else if (model_on) begin
      if (exp_v.ctl[8] && instr_valid) begin
        build(instr);
        hs_cyc = cyc;
        hs_count++;
      end
      if (sched.size() > 0) exp_v = sched.pop_front();
      else                  exp_v = mk(9'b100000000, '0, '0, 1'b0);
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [8:0] act;
    if (model_on) begin
      act = {instr_ready, busy, a_enable, addsub, xor_ctrl, mul_out_ctrl, acc_enable, done, err};
      total++;
      if (act !== exp_v.ctl) begin
        bad++;
        $display("FAIL ctl cyc=%0d: got %b want %b", cyc, act, exp_v.ctl);
      end
      if (exp_v.chk_addr) begin
        total++;
        if ({rf_addr_a, rf_addr_b} !== {exp_v.ra, exp_v.rb}) begin
          bad++;
          $display("FAIL addr cyc=%0d: got %h%h want %h%h", cyc, rf_addr_a, rf_addr_b, exp_v.ra, exp_v.rb);
        end
      end
      if (cyc == hs_cyc + 1) begin a_cnt = 0; acc_cnt = 0; end
      if (rst) acc_since_rst = 0;
      if (a_enable === 1'b1) begin
        a_cnt++; a_lat = cyc - hs_cyc; a_ra = int'(rf_addr_a); a_rb = int'(rf_addr_b);
      end
      if (acc_enable === 1'b1) begin
        acc_cnt++; acc_since_rst++; acc_lat = cyc - hs_cyc;
        acc_ctl = int'({addsub, xor_ctrl, mul_out_ctrl});
      end
      if (done === 1'b1) begin done_lat = cyc - hs_cyc; err_seen = int'(err); end
    end
  end

  task automatic check(string name, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic send(logic [15:0] w, bit hold);
    int start;
    start = hs_count;
    instr = w;
    instr_valid = 1'b1;
    for (int k = 0; k < 60 && hs_count == start; k++) begin
      @(posedge clk); #2;
    end
    if (hs_count == start) check("accept_timeout", hs_count - start, 1);
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80 && !(exp_v.ctl[8] && sched.size() == 0); k++) begin
      @(posedge clk); #2;
    end
    if (!exp_v.ctl[8]) check("idle_timeout", int'(exp_v.ctl[8]), 1);
  endtask

  task automatic run_op(string name, logic [15:0] w, int want_acc, int want_done, int want_ctl);
    send(w, 1'b0);
    wait_idle();
    check({name, "_a_lat"}, a_lat, 1);
    check({name, "_acc_lat"}, acc_lat, want_acc);
    check({name, "_done_lat"}, done_lat, want_done);
    check({name, "_ctl"}, acc_ctl, want_ctl);
    check({name, "_one_a"}, a_cnt, 1);
    check({name, "_one_acc"}, acc_cnt, 1);
  endtask

  initial begin
    int lda_hs, add_hs;
    logic [31:0] r;
    logic [3:0]  opc;
    bit          hold;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(instr_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'({a_enable, addsub, xor_ctrl, mul_out_ctrl, acc_enable, done, err}), 0);
    @(posedge clk); #2;

    run_op("add", 16'h1120, 3, 4, 0);
    check("add_ra", a_ra, 1);
    check("add_rb", a_rb, 2);
    run_op("sub", 16'h2340, 3, 4, 4);
    run_op("xor", 16'h3560, 3, 4, 2);
    run_op("mul", 16'h4780, 3 + MW, 4 + MW, 1);

    send(16'h9000, 1'b0);
    wait_idle();
    check("ill_done_lat", done_lat, 1);
    check("ill_err", err_seen, 1);
    check("ill_no_a", a_cnt, 0);
    check("ill_no_acc", acc_cnt, 0);
    send(16'h0000, 1'b0);
    wait_idle();
    check("nop_done_lat", done_lat, 1);
    check("nop_err", err_seen, 0);

    // Valid held high across a queue of three instructions.
    send(16'h1340, 1'b1);
    add_hs = hs_cyc;
    send(16'h5ab0, 1'b1);
    lda_hs = hs_cyc;
    check("b2b_add_gap", lda_hs - add_hs, 5);
    send(16'h3cd0, 1'b1);
    check("lda_done_lat", done_lat, 2);
    check("b2b_lda_gap", hs_cyc - lda_hs, 3);
    instr_valid = 1'b0;
    wait_idle();
    check("b2b_xor_done_lat", done_lat, 4);

    // Reset while a MUL sits in EXEC.
    send(16'h4120, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(instr_ready), 1);
    check("abort_busy", int'(busy), 0);
    repeat (8) @(posedge clk);
    #2;
    check("abort_no_acc", acc_since_rst, 0);
    run_op("post_rst_add", 16'h1560, 3, 4, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      opc = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      hold = bit'($urandom_range(0, 1));
      send({opc, r[11:0]}, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #2;
        end
      end
    end
    instr_valid = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
